// File: rtl/fft_adc_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fft_adc_loader
//  Description : Captures one frame of N signed ADC samples and writes them,
//                in bank-major order, into the four FFT input RAM banks. After
//                the last sample it pulses oSTART once. It then waits for a
//                rising edge of the FFT done flag before returning to IDLE.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iCLK          rising-edge clock
//    iRESET        asynchronous active-low reset
//    iSAMPLE       signed ADC sample, D_BIT-1 bits
//    iVALID        iSAMPLE valid this cycle
//    iARM          request capture of one frame (honoured only in IDLE)
//    iFFT_RDY      FFT done flag; its rising edge ends WAIT_FFT
//    oDATA         sample to the FFT RAM write port
//    oADDR_WR_0..3 bank write addresses (all four carry the same address)
//    oWE_0..3      bank write enables (at most one high per cycle)
//    oSTART        one-cycle FFT launch pulse
//    oBUSY         high in any state other than IDLE
//    oOVF          sticky flag: a sample arrived while no frame was open
// ============================================================================
module fft_adc_loader #(
   parameter int N     = 4096,   // points per frame, power of 4, N/4 == 2**A_BIT
   parameter int A_BIT = 10,     // bank address width
   parameter int D_BIT = 16      // FFT internal data width
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic [D_BIT-2:0]   iSAMPLE,
   input  logic               iVALID,
   input  logic               iARM,
   input  logic               iFFT_RDY,
   output logic [D_BIT-2:0]   oDATA,
   output logic [A_BIT-1:0]   oADDR_WR_0,
   output logic [A_BIT-1:0]   oADDR_WR_1,
   output logic [A_BIT-1:0]   oADDR_WR_2,
   output logic [A_BIT-1:0]   oADDR_WR_3,
   output logic               oWE_0,
   output logic               oWE_1,
   output logic               oWE_2,
   output logic               oWE_3,
   output logic               oSTART,
   output logic               oBUSY,
   output logic               oOVF
);

   // Sample counter spans the whole frame: two bank-select bits on top of the
   // bank address.
   localparam int CNT_W = A_BIT + 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FILL     = 2'd1,
      LAUNCH   = 2'd2,
      WAIT_FFT = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               rdy_prev;
   logic               rdy_rise;
   logic               accept;
   logic               last_sample;
   logic [D_BIT-2:0]   data_r;
   logic [A_BIT-1:0]   addr_r;
   logic [3:0]         we_r;
   logic               start_r;
   logic               busy_r;
   logic               ovf_r;

   assign rdy_rise    = iFFT_RDY & ~rdy_prev;
   assign accept      = (state == FILL) & iVALID;
   assign last_sample = &cnt;   // cnt == N-1

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (iARM)                  state_nxt = FILL;
         FILL:     if (accept && last_sample) state_nxt = LAUNCH;
         LAUNCH:                              state_nxt = WAIT_FFT;
         WAIT_FFT: if (rdy_rise)              state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         cnt      <= '0;
         rdy_prev <= 1'b0;
         data_r   <= '0;
         addr_r   <= '0;
         we_r     <= '0;
         start_r  <= 1'b0;
         busy_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         // The done flag is tracked in every state, so a level that is already
         // high when WAIT_FFT is entered never looks like a fresh edge.
         rdy_prev <= iFFT_RDY;
         // Decoding the next state keeps oBUSY aligned with the state register.
         busy_r   <= (state_nxt != IDLE);
         // LAUNCH lasts one cycle; registering it places the pulse one cycle
         // after the final write enable.
         start_r  <= (state == LAUNCH);
         we_r     <= '0;

         if ((state == IDLE) && iARM) begin
            cnt   <= '0;
            ovf_r <= 1'b0;
         end

         if (accept) begin
            data_r                  <= iSAMPLE;
            addr_r                  <= cnt[A_BIT-1:0];
            we_r[cnt[CNT_W-1 -: 2]] <= 1'b1;
            cnt                     <= cnt + 1'b1;   // wraps to 0 after N-1
         end

         if (iVALID && ((state == LAUNCH) || (state == WAIT_FFT))) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign oDATA      = data_r;
   assign oADDR_WR_0 = addr_r;
   assign oADDR_WR_1 = addr_r;
   assign oADDR_WR_2 = addr_r;
   assign oADDR_WR_3 = addr_r;
   assign oWE_0      = we_r[0];
   assign oWE_1      = we_r[1];
   assign oWE_2      = we_r[2];
   assign oWE_3      = we_r[3];
   assign oSTART     = start_r;
   assign oBUSY      = busy_r;
   assign oOVF       = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_fft_adc_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_adc_loader
//  Description : Self-checking bench for fft_adc_loader. Expected writes are
//                queued as samples are driven and compared when the loader
//                produces write enables.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_adc_loader;

   localparam int N     = 4096;
   localparam int A_BIT = 10;
   localparam int D_BIT = 16;
   localparam int BANK  = N / 4;

   logic               iCLK    = 1'b0;
   logic               iRESET  = 1'b0;
   logic [D_BIT-2:0]   iSAMPLE = '0;
   logic               iVALID  = 1'b0;
   logic               iARM    = 1'b0;
   logic               iFFT_RDY = 1'b0;
   logic [D_BIT-2:0]   oDATA;
   logic [A_BIT-1:0]   oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
   logic               oWE_0, oWE_1, oWE_2, oWE_3;
   logic               oSTART, oBUSY, oOVF;

   fft_adc_loader #(.N(N), .A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iSAMPLE    (iSAMPLE),
      .iVALID     (iVALID),
      .iARM       (iARM),
      .iFFT_RDY   (iFFT_RDY),
      .oDATA      (oDATA),
      .oADDR_WR_0 (oADDR_WR_0),
      .oADDR_WR_1 (oADDR_WR_1),
      .oADDR_WR_2 (oADDR_WR_2),
      .oADDR_WR_3 (oADDR_WR_3),
      .oWE_0      (oWE_0),
      .oWE_1      (oWE_1),
      .oWE_2      (oWE_2),
      .oWE_3      (oWE_3),
      .oSTART     (oSTART),
      .oBUSY      (oBUSY),
      .oOVF       (oOVF)
   );

   always #5 iCLK = ~iCLK;

   typedef struct packed {
      logic [1:0]         bank;
      logic [A_BIT-1:0]   addr;
      logic [D_BIT-2:0]   data;
   } wr_t;

   wr_t                exp_q[$];
   wr_t                exp_wr;
   logic [3:0]         we_seen;
   logic [D_BIT-2:0]   last_data = '0;
   logic [A_BIT-1:0]   last_addr = '0;
   int                 n_checks = 0;
   int                 n_fail   = 0;
   int                 idx = 0;
   int                 start_cnt = 0;
   int                 write_cnt = 0;
   int                 cyc = 0;
   int                 last_we_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Output monitor / scoreboard consumer
   // ------------------------------------------------------------------------
   always @(negedge iCLK) begin
      we_seen = {oWE_3, oWE_2, oWE_1, oWE_0};
      if (!iRESET) begin
         exp_q.delete();
         last_data = '0;
         last_addr = '0;
      end else begin
         cyc++;
         if (we_seen != 4'b0000) begin
            write_cnt++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_we", {60'd0, we_seen}, 64'd0);
            end else begin
               exp_wr = exp_q.pop_front();
               check("we_bank", {60'd0, we_seen}, {60'd0, 4'b0001 << exp_wr.bank});
               check("wr_addr", {24'd0, oADDR_WR_3, oADDR_WR_2, oADDR_WR_1, oADDR_WR_0},
                     {24'd0, {4{exp_wr.addr}}});
               check("wr_data", {49'd0, oDATA}, {49'd0, exp_wr.data});
               last_data = exp_wr.data;
               last_addr = exp_wr.addr;
            end
         end else begin
            check("hold_data", {49'd0, oDATA}, {49'd0, last_data});
            check("hold_addr", {24'd0, oADDR_WR_3, oADDR_WR_2, oADDR_WR_1, oADDR_WR_0},
                  {24'd0, {4{last_addr}}});
         end
         if (oSTART) begin
            start_cnt++;
            check("start_latency", 64'(cyc - last_we_cyc), 64'd1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic push_sample(input logic [D_BIT-2:0] s, input logic arm_too);
      wr_t w;
      step();
      iVALID  = 1'b1;
      iSAMPLE = s;
      iARM    = arm_too;
      w.bank  = 2'(idx / BANK);
      w.addr  = A_BIT'(idx % BANK);
      w.data  = s;
      exp_q.push_back(w);
      idx++;
   endtask

   task automatic gap(input logic arm_too);
      step();
      iVALID = 1'b0;
      iARM   = arm_too;
   endtask

   // iVALID is held high with a junk sample during the arm cycle: IDLE must ignore it.
   task automatic arm();
      step();
      iARM    = 1'b1;
      iVALID  = 1'b1;
      iSAMPLE = '1;
      idx     = 0;
   endtask

   task automatic finish_frame(input int exp_starts);
      gap(1'b0);
      gap(1'b0);
      gap(1'b0);
      check("start_count", 64'(start_cnt), 64'(exp_starts));
      check("busy_wait_fft", {63'd0, oBUSY}, 64'd1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic fft_done();
      step();
      iFFT_RDY = 1'b1;
      #3;
      check("busy_at_rdy_rise", {63'd0, oBUSY}, 64'd1);
      step();
      check("busy_after_rdy_rise", {63'd0, oBUSY}, 64'd0);
      iFFT_RDY = 1'b0;
   endtask

   function automatic logic [63:0] all_outputs();
      return {2'd0, oDATA, oADDR_WR_3, oADDR_WR_2, oADDR_WR_1, oADDR_WR_0,
              oWE_3, oWE_2, oWE_1, oWE_0, oSTART, oBUSY, oOVF};
   endfunction

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      #1;
      check("reset_outputs", all_outputs(), 64'd0);
      repeat (3) @(posedge iCLK);
      #3 iRESET = 1'b1;

      // Frame 1: sample = index, back-to-back; then iVALID held through LAUNCH/WAIT_FFT.
      arm();
      for (int i = 0; i < N; i++) push_sample(D_BIT'(i), 1'b0) ;
      for (int i = 0; i < 10; i++) begin
         step();
         iVALID = 1'b1;
         iARM   = 1'b0;
      end
      finish_frame(1);
      check("ovf_set", {63'd0, oOVF}, 64'd1);
      fft_done();
      check("ovf_sticky_idle", {63'd0, oOVF}, 64'd1);
      check("writes_frame1", 64'(write_cnt), 64'(N));

      // Frame 2: constant 100 with iVALID toggling; iFFT_RDY already high at frame end.
      arm();
      for (int i = 0; i < N; i++) begin
         push_sample(15'd100, 1'b0);
         if (i == 0) check("ovf_cleared_by_arm", {63'd0, oOVF}, 64'd0);
         if (i == N - 10) iFFT_RDY = 1'b1;
         gap(1'b0);
      end
      finish_frame(2);
      repeat (5) step();
      check("busy_level_rdy", {63'd0, oBUSY}, 64'd1);
      iFFT_RDY = 1'b0;
      repeat (49) step();
      check("busy_before_rise", {63'd0, oBUSY}, 64'd1);
      fft_done();
      check("writes_frame2", 64'(write_cnt), 64'(2 * N));

      // Frame 3: reset after 2000 samples.
      arm();
      for (int i = 0; i < 2000; i++) push_sample(15'($urandom), 1'b0);
      gap(1'b0);
      gap(1'b0);
      #2 iRESET = 1'b0;
      #1;
      check("async_reset_outputs", all_outputs(), 64'd0);
      step();
      step();
      check("reset_held_outputs", all_outputs(), 64'd0);
      check("no_start_after_reset", 64'(start_cnt), 64'd2);
      #2 iRESET = 1'b1;
      // Without a new arm, valid samples must not be written.
      step();
      iVALID = 1'b1;
      step();
      iVALID = 1'b1;
      gap(1'b0);
      gap(1'b0);
      check("idle_after_reset", {61'd0, oSTART, oBUSY, oOVF}, 64'd0);

      // Frame 4: random data, gaps, and arm pulses sprinkled through FILL and WAIT_FFT.
      arm();
      for (int i = 0; i < N; i++) begin
         push_sample(15'($urandom), (i % 300) == 7);
         if ((i % 7) == 3) gap((i % 500) == 3);
      end
      finish_frame(3);
      for (int i = 0; i < 5; i++) begin
         step();
         iARM = 1'b1;
      end
      step();
      check("busy_arm_in_wait", {63'd0, oBUSY}, 64'd1);
      iARM     = 1'b1;
      iFFT_RDY = 1'b1;
      step();
      iARM     = 1'b0;
      iFFT_RDY = 1'b0;
      check("rdy_with_arm_to_idle", {63'd0, oBUSY}, 64'd0);
      gap(1'b0);
      gap(1'b0);
      check("stays_idle", {63'd0, oBUSY}, 64'd0);
      check("writes_total", 64'(write_cnt), 64'(3 * N + 2000));
      check("starts_total", 64'(start_cnt), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_adc_loader.md
FFT_ADC_LOADER -- requirements
Module: fft_adc_loader

Interface
REQ-001 SHALL have parameter N, default 4096, points per FFT frame (power of 4, N >= 16).
REQ-002 SHALL have parameter A_BIT, default 10, bank address width; N/4 = 2**A_BIT is a fixed design rule.
REQ-003 SHALL have parameter D_BIT, default 16, FFT internal data width; ADC sample width is D_BIT-1 (no bit expansion).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: iCLK in 1, rising-edge clock; iRESET in 1, asynchronous active-low reset.
REQ-005 iSAMPLE  in  D_BIT-1  signed ADC sample.
REQ-006 iVALID  in  1  iSAMPLE valid this cycle.
REQ-007 iARM  in  1  request capture of one frame.
REQ-008 iFFT_RDY  in  1  FFT done flag from the FFT core.
REQ-009 oDATA  out  D_BIT-1  sample to FFT RAM write port (feeds fft_top iDATA).
REQ-010 oADDR_WR_0..oADDR_WR_3  out  A_BIT each  bank write addresses.
REQ-011 oWE_0..oWE_3  out  1 each  bank write enables.
REQ-012 oSTART  out  1  one-cycle FFT launch pulse.
REQ-013 oBUSY  out  1  high in any state other than IDLE.
REQ-014 oOVF  out  1  sticky sample-dropped flag.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, LAUNCH, WAIT_FFT.
REQ-016 IDLE: iARM=1 -> FILL; sample counter cnt (log2 N bits) cleared to 0, oOVF cleared; iVALID ignored, no write.
REQ-017 FILL: each cycle with iVALID=1 SHALL write the sample at bank = cnt[MSB:MSB-1], addr = cnt[A_BIT-1:0], then cnt+1 (bank-major order: bank 0 addr 0..N/4-1, then bank 1, ...).
REQ-018 Write latency SHALL be 1 cycle: sample accepted at edge k appears on oDATA, all four oADDR_WR_x = addr, and exactly one oWE_bank = 1 during cycle k+1.
REQ-019 oWE_x SHALL be 0 in every cycle with no accepted sample; gaps in iVALID SHALL insert no writes and not advance cnt.
REQ-020 oDATA and oADDR_WR_x SHALL hold their last values when no write occurs.
REQ-021 Accepting sample cnt = N-1 SHALL move FSM to LAUNCH; cnt wraps to 0.
REQ-022 LAUNCH: oSTART = 1 for exactly one cycle, the cycle after the last oWE pulse; then -> WAIT_FFT.
REQ-023 WAIT_FFT: SHALL detect the rising edge of iFFT_RDY (registered previous value); on edge -> IDLE. A level-high iFFT_RDY already present on entry SHALL NOT end WAIT_FFT.
REQ-024 iVALID=1 in LAUNCH or WAIT_FFT SHALL set oOVF (sticky until next accepted iARM); the sample is discarded, no write.
REQ-025 iARM outside IDLE SHALL be ignored; iARM and a rising iFFT_RDY in the same WAIT_FFT cycle -> IDLE only (arm needs a later cycle).
REQ-026 oBUSY SHALL be registered state decode: 0 in IDLE, 1 in FILL/LAUNCH/WAIT_FFT.

Reset
REQ-027 iRESET=0 SHALL asynchronously force state IDLE, cnt=0, oDATA=0, all oADDR_WR_x=0, all oWE_x=0, oSTART=0, oBUSY=0, oOVF=0, edge register=0.
REQ-028 Reset mid-FILL SHALL abandon the frame with no oSTART; partial RAM content is not cleared.
REQ-029 After iRESET release, the first action SHALL be a new iARM in IDLE.

Verification
REQ-030 N=4096: iARM, then 4096 back-to-back iVALID with sample = index -> oWE_0 at addr 0..1023 with data 0..1023, oWE_3 at addr 1023 carries 4095; oSTART single pulse 1 cycle after last write.
REQ-031 Constant 100 with iVALID toggling 1/0 -> 4096 writes total, all data 100, no oWE during gaps, cnt advances only on valid.
REQ-032 iVALID held high after frame end during WAIT_FFT -> oOVF=1 and no oWE; next iARM in IDLE -> oOVF=0.
REQ-033 iFFT_RDY already high entering WAIT_FFT, drops, rises 50 cycles later -> oBUSY falls 1 cycle after the rise, not before.
REQ-034 iRESET=0 asserted after 2000 samples -> all outputs 0 immediately (async), no oSTART; re-arm and full frame completes normally.
REQ-035 iARM pulsed during FILL and WAIT_FFT -> no effect on cnt, writes, or state.
